// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch (IF)
// and the MEM-stage load/store path. Each access is a one-cycle chip-select
// followed by a fixed wait of MEM_LAT edges (loads/fetches) or one edge
// (stores). The stall output holds every stage register until every request
// of the current pipeline cycle has been served.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request and address
//   if_rdata/if_done         registered fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  MEM-stage request (dm_we==0 means load)
//   dm_rdata/dm_done         registered load data, one-cycle completion pulse
//   mem_cs/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                memory read data
//   stall_pipe               combinational pipeline stall
module mem_port_arbiter #(
    parameter int addrWidth = 15,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [addrWidth-1:0] if_addr,
    output logic [31:0]          if_rdata,
    output logic                 if_done,
    input  logic                 dm_req,
    input  logic [3:0]           dm_we,
    input  logic [addrWidth-1:0] dm_addr,
    input  logic [31:0]          dm_wdata,
    output logic [31:0]          dm_rdata,
    output logic                 dm_done,
    output logic                 mem_cs,
    output logic [3:0]           mem_we,
    output logic [addrWidth-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 stall_pipe
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_DM = 2'd1,
        BUSY_IF = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    state_t     state_r;
    logic [2:0] cnt_r;
    logic       if_served_r;
    logic       dm_served_r;
    logic       if_pend_s;
    logic       dm_pend_s;
    logic       stall_s;

    // Outstanding-request detection and the pipeline stall; stall is forced
    // low while reset is asserted so every output reads zero during reset.
    always_comb begin
        if_pend_s = 1'b0;
        dm_pend_s = 1'b0;
        stall_s   = 1'b0;
        if_pend_s = if_req & ~if_served_r;
        dm_pend_s = dm_req & ~dm_served_r;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = if_pend_s | dm_pend_s;
        end
    end

    assign stall_pipe = stall_s;

    // Arbitration FSM, access sequencing, response capture and served flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            if_served_r <= 1'b0;
            dm_served_r <= 1'b0;
            mem_cs      <= 1'b0;
            mem_we      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0000_0000;
            if_rdata    <= 32'h0000_0000;
            dm_rdata    <= 32'h0000_0000;
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
        end else begin
            // Chip select and done flags are single-cycle pulses.
            mem_cs  <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    // DM wins a tie: it belongs to the older instruction.
                    if (dm_pend_s) begin
                        state_r   <= BUSY_DM;
                        mem_cs    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        cnt_r     <= LAT_C;
                    end else if (if_pend_s) begin
                        state_r   <= BUSY_IF;
                        mem_cs    <= 1'b1;
                        mem_we    <= 4'b0000;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'h0000_0000;
                        cnt_r     <= LAT_C;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_DM: begin
                    // mem_we still holds the latched enables: a store finishes
                    // one edge after its chip-select cycle, a load waits MEM_LAT.
                    if ((mem_we != 4'b0000) || (cnt_r == 3'd1)) begin
                        if (mem_we == 4'b0000) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            dm_rdata <= dm_rdata;
                        end
                        dm_done     <= 1'b1;
                        dm_served_r <= 1'b1;
                        cnt_r       <= 3'd0;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                BUSY_IF: begin
                    if (cnt_r == 3'd1) begin
                        if_rdata    <= mem_rdata;
                        if_done     <= 1'b1;
                        if_served_r <= 1'b1;
                        cnt_r       <= 3'd0;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
            // The pipeline advances at this edge: a new cycle's requests start
            // unserved. Placed last so it overrides a same-edge completion of a
            // requester that already dropped its request.
            if (!stall_s) begin
                if_served_r <= 1'b0;
                dm_served_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MEM_LAT=2 main instance)
// plus two extra instances (MEM_LAT=1 and 7) for the latency sweep.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each table row is one clock cycle.
module tb_mem_port_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          dm_req = 1'b0;
    logic [3:0]    dm_we = 4'b0000;
    logic [AW-1:0] dm_addr = '0;
    logic [31:0]   dm_wdata = 32'h0;
    logic [31:0]   mem_rdata = 32'h0;
    logic [31:0]   if_rdata, dm_rdata, mem_wdata;
    logic          if_done, dm_done, mem_cs, stall_pipe;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.addrWidth(AW), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_pipe(stall_pipe)
    );

    // Latency-sweep instances: load-only, fixed read data.
    logic          sw1_req = 1'b0, sw7_req = 1'b0;
    logic          sw_zero = 1'b0;
    logic [AW-1:0] sw_addr = 15'h0010;
    logic [31:0]   sw_data = 32'h0000_1234;
    logic [31:0]   l1_ifr, l1_dmr, l1_wd, l7_ifr, l7_dmr, l7_wd;
    logic          l1_ifd, l1_dmd, l1_cs, l1_st, l7_ifd, l7_dmd, l7_cs, l7_st;
    logic [3:0]    l1_we, l7_we;
    logic [AW-1:0] l1_ad, l7_ad;

    mem_port_arbiter #(.addrWidth(AW), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(sw_zero), .if_addr(sw_addr), .if_rdata(l1_ifr), .if_done(l1_ifd),
        .dm_req(sw1_req), .dm_we(4'b0000), .dm_addr(sw_addr), .dm_wdata(32'h0),
        .dm_rdata(l1_dmr), .dm_done(l1_dmd),
        .mem_cs(l1_cs), .mem_we(l1_we), .mem_addr(l1_ad), .mem_wdata(l1_wd),
        .mem_rdata(sw_data), .stall_pipe(l1_st)
    );

    mem_port_arbiter #(.addrWidth(AW), .MEM_LAT(7)) u_lat7 (
        .clk(clk), .rst(rst),
        .if_req(sw_zero), .if_addr(sw_addr), .if_rdata(l7_ifr), .if_done(l7_ifd),
        .dm_req(sw7_req), .dm_we(4'b0000), .dm_addr(sw_addr), .dm_wdata(32'h0),
        .dm_rdata(l7_dmr), .dm_done(l7_dmd),
        .mem_cs(l7_cs), .mem_we(l7_we), .mem_addr(l7_ad), .mem_wdata(l7_wd),
        .mem_rdata(sw_data), .stall_pipe(l7_st)
    );

    typedef struct {
        logic          r_rst;
        logic          r_if_req;
        logic [AW-1:0] r_if_addr;
        logic          r_dm_req;
        logic [3:0]    r_dm_we;
        logic [AW-1:0] r_dm_addr;
        logic [31:0]   r_dm_wdata;
        logic [31:0]   r_mem;
        logic          e_cs;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic          e_ifd;
        logic [31:0]   e_ifr;
        logic          e_dmd;
        logic [31:0]   e_dmr;
        logic          e_stall;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r_rst, input logic r_if_req, input logic [AW-1:0] r_if_addr,
                       input logic r_dm_req, input logic [3:0] r_dm_we, input logic [AW-1:0] r_dm_addr,
                       input logic [31:0] r_dm_wdata, input logic [31:0] r_mem,
                       input logic e_cs, input logic [3:0] e_we, input logic [AW-1:0] e_addr,
                       input logic [31:0] e_wdata, input logic e_ifd, input logic [31:0] e_ifr,
                       input logic e_dmd, input logic [31:0] e_dmr, input logic e_stall);
        vec_t v;
        v.r_rst = r_rst; v.r_if_req = r_if_req; v.r_if_addr = r_if_addr;
        v.r_dm_req = r_dm_req; v.r_dm_we = r_dm_we; v.r_dm_addr = r_dm_addr;
        v.r_dm_wdata = r_dm_wdata; v.r_mem = r_mem;
        v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_ifd = e_ifd; v.e_ifr = e_ifr; v.e_dmd = e_dmd; v.e_dmr = e_dmr; v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [127:0] act_v, exp_v;
        logic         bus_v;
        int           drop_k, cs_cnt, done_cnt, d1, d7;
        logic [31:0]  word_v, r1, r7;

        // rst  ifq ifaddr    dmq we     dmaddr     wdata          mem             cs  we     addr       wdata          ifd ifr            dmd dmr            stall
        add(1'b1,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h0,          1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        // single load
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hDEADBEEF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hDEADBEEF,   1'b1,4'h0,15'h0040,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hDEADBEEF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hDEADBEEF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b1,32'hDEADBEEF, 1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'hDEADBEEF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b0);
        // store: dm_rdata must keep the earlier load value
        add(1'b0,1'b0,15'h0000,1'b1,4'h3,15'h0100,32'h12345678, 32'hFFFFFFFF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h3,15'h0100,32'h12345678, 32'hFFFFFFFF,   1'b1,4'h3,15'h0100,32'h12345678, 1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h3,15'h0100,32'h12345678, 32'hFFFFFFFF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b1,32'hDEADBEEF, 1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'hFFFFFFFF,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b0);
        // simultaneous IF and DM: DM first, IF after one idle cycle
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h11112222,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h11112222,   1'b1,4'h0,15'h0200,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h11112222,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h33334444,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b1,32'h11112222, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h33334444,   1'b1,4'h0,15'h0008,32'h0,        1'b0,32'h0,        1'b0,32'h11112222, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h33334444,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h11112222, 1'b1);
        add(1'b0,1'b1,15'h0008,1'b1,4'h0,15'h0200,32'h0,        32'h33334444,   1'b0,4'h0,15'h0000,32'h0,        1'b1,32'h33334444, 1'b0,32'h11112222, 1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h33334444,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h33334444, 1'b0,32'h11112222, 1'b0);
        // reset in the middle of a load
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hCAFEF00D,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h33334444, 1'b0,32'h11112222, 1'b1);
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hCAFEF00D,   1'b1,4'h0,15'h0040,32'h0,        1'b0,32'h33334444, 1'b0,32'h11112222, 1'b1);
        add(1'b1,1'b0,15'h0000,1'b1,4'h0,15'h0040,32'h0,        32'hCAFEF00D,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        add(1'b1,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'hCAFEF00D,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'hCAFEF00D,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'hCAFEF00D,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        // requester drops dm_req mid-access: access still completes
        add(1'b0,1'b0,15'h0000,1'b1,4'h0,15'h0044,32'h0,        32'h0BADCAFE,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h0BADCAFE,   1'b1,4'h0,15'h0044,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h0BADCAFE,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h0BADCAFE,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b1,32'h0BADCAFE, 1'b0);
        add(1'b0,1'b0,15'h0000,1'b0,4'h0,15'h0000,32'h0,        32'h0BADCAFE,   1'b0,4'h0,15'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0BADCAFE, 1'b0);

        // Apply the table, one row per cycle. Memory-bus fields are compared
        // only when a chip select is expected or reset is asserted.
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].r_rst;
            if_req    = vecs[i].r_if_req;
            if_addr   = vecs[i].r_if_addr;
            dm_req    = vecs[i].r_dm_req;
            dm_we     = vecs[i].r_dm_we;
            dm_addr   = vecs[i].r_dm_addr;
            dm_wdata  = vecs[i].r_dm_wdata;
            mem_rdata = vecs[i].r_mem;
            @(negedge clk);
            bus_v = vecs[i].e_cs | vecs[i].r_rst;
            act_v = '0;
            exp_v = '0;
            if (bus_v) begin
                act_v = {9'h0, mem_cs, mem_we, mem_addr, mem_wdata, if_done, if_rdata, dm_done, dm_rdata, stall_pipe};
                exp_v = {9'h0, vecs[i].e_cs, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
                         vecs[i].e_ifd, vecs[i].e_ifr, vecs[i].e_dmd, vecs[i].e_dmr, vecs[i].e_stall};
            end else begin
                act_v = {60'h0, mem_cs, if_done, if_rdata, dm_done, dm_rdata, stall_pipe};
                exp_v = {60'h0, vecs[i].e_cs, vecs[i].e_ifd, vecs[i].e_ifr,
                         vecs[i].e_dmd, vecs[i].e_dmr, vecs[i].e_stall};
            end
            chk($sformatf("row%0d", i), act_v, exp_v);
            @(posedge clk);
            #1;
        end

        // Fetch-only stream: if_req held high, address advances when stall drops.
        dm_req = 1'b0;
        dm_we  = 4'b0000;
        if_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if_addr   = 15'(n * 4);
            word_v    = 32'hF000_0000 | 32'(n * 4);
            mem_rdata = word_v;
            drop_k    = -1;
            cs_cnt    = 0;
            done_cnt  = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (mem_cs) cs_cnt++;
                if (if_done) done_cnt++;
                if (!stall_pipe) begin
                    drop_k = k;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk($sformatf("fetch%0d_latency", n), 128'(drop_k), 128'(3));
            chk($sformatf("fetch%0d_cs_count", n), 128'(cs_cnt), 128'(1));
            chk($sformatf("fetch%0d_done_count", n), 128'(done_cnt), 128'(1));
            chk($sformatf("fetch%0d_rdata", n), 128'(if_rdata), 128'(word_v));
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;

        // Latency sweep: done arrives MEM_LAT+1 cycles after the request cycle.
        sw1_req = 1'b1;
        sw7_req = 1'b1;
        d1 = -1;
        d7 = -1;
        r1 = 32'h0;
        r7 = 32'h0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (l1_dmd && d1 < 0) begin
                d1 = k;
                r1 = l1_dmr;
                sw1_req = 1'b0;
            end
            if (l7_dmd && d7 < 0) begin
                d7 = k;
                r7 = l7_dmr;
                sw7_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sw1_req = 1'b0;
        sw7_req = 1'b0;
        chk("lat1_done_cycle", 128'(d1), 128'(2));
        chk("lat7_done_cycle", 128'(d7), 128'(8));
        chk("lat1_rdata", 128'(r1), 128'(32'h0000_1234));
        chk("lat7_rdata", 128'(r7), 128'(32'h0000_1234));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
